// File: rtl/operand_arbiter.sv
// Round-robin arbiter sharing one operand path among NREQ requesters, with a
// single-entry registered output stage and a valid/ready handshake toward the ALU.
module operand_arbiter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned SELW  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         gnt,
  output logic [SELW-1:0]         sel,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SELW-1:0]         out_src,
  input  logic                    out_ready,
  output logic                    busy
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  logic [SELW-1:0]  src_q;
  logic [SELW-1:0]  last_q;
  logic [SELW-1:0]  sel_q;

  logic             load;
  logic             found;
  logic [SELW-1:0]  winner;
  logic [WIDTH-1:0] win_word;

  // Search starts just after the previous winner and wraps modulo NREQ.
  always_comb begin
    int unsigned idx;
    logic [SELW-1:0] idx_s;
    idx    = 0;
    idx_s  = '0;
    found  = 1'b0;
    winner = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx   = (32'(last_q) + k) % NREQ;
      idx_s = SELW'(idx);
      if (!found && req[idx_s]) begin
        found  = 1'b1;
        winner = idx_s;
      end
    end
  end

  assign load     = !rst && ((state_q == StEmpty) || out_ready) && found;
  assign win_word = req_data[32'(winner)*WIDTH +: WIDTH];

  always_comb begin
    gnt = '0;
    if (load) gnt[winner] = 1'b1;
  end

  assign sel       = load ? winner : sel_q;
  assign out_valid = (state_q == StFull);
  assign out_data  = data_q;
  assign out_src   = src_q;
  assign busy      = out_valid & ~out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      data_q  <= '0;
      src_q   <= '0;
      last_q  <= SELW'(NREQ - 1);
      sel_q   <= '0;
    end else begin
      sel_q <= sel;
      unique case (state_q)
        StEmpty: begin
          if (load) begin
            data_q  <= win_word;
            src_q   <= winner;
            last_q  <= winner;
            state_q <= StFull;
          end
        end
        StFull: begin
          // Drain and refill on the same edge keeps the stage full with no bubble.
          if (load) begin
            data_q  <= win_word;
            src_q   <= winner;
            last_q  <= winner;
          end else if (out_ready) begin
            state_q <= StEmpty;
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

endmodule
